// File: rtl/gen_valid_mc.sv
// gen_valid_mc: multi-channel valid/ready sample generator.
// Each channel produces registered valid pulses from a programmable period
// (free-running PERIODIC, counted ONESHOT bursts, or CONT every cycle), counts
// accepted transfers and flags ticks dropped against a stalled consumer.
module gen_valid_mc #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned SAMP_W = 32
) (
    input  logic                  clk,
    input  logic                  rn,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [NCH*CNT_W-1:0]  period,
    input  logic [CNT_W-1:0]      burst_len,
    input  logic                  start,
    input  logic                  clr_ovr,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH-1:0]        out_valid,
    output logic [NCH*SAMP_W-1:0] samp_cnt,
    output logic [NCH-1:0]        overrun,
    output logic                  busy
);

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_CONT     = 2'd2,
        MODE_OFF      = 2'd3
    } mode_e;

    mode_e              mode_cur;
    mode_e              mode_prev_q;
    logic               mode_chg;
    logic               launch;

    logic [CNT_W-1:0]   cnt_q  [NCH];
    logic [CNT_W-1:0]   cnt_d  [NCH];
    logic [CNT_W-1:0]   rem_q  [NCH];
    logic [CNT_W-1:0]   rem_d  [NCH];
    logic [SAMP_W-1:0]  samp_q [NCH];
    logic [SAMP_W-1:0]  samp_d [NCH];
    logic [CNT_W-1:0]   eff_m1 [NCH];

    logic [NCH-1:0]     valid_q, valid_d;
    logic [NCH-1:0]     ovr_q, ovr_d;
    logic [NCH-1:0]     cnt_en;
    logic [NCH-1:0]     tick;
    logic [NCH-1:0]     xfer;
    logic [NCH-1:0]     rem_nz;

    assign mode_cur = mode_e'(mode);
    // The previous-cycle mode is tracked so a change can flush cnt/remaining.
    assign mode_chg = (mode_cur != mode_prev_q);

    // Busy spans remaining ticks plus any still-pending final valid.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            rem_nz[i] = (rem_q[i] != '0);
        end
        busy = (mode_cur == MODE_ONESHOT) && ((|rem_nz) || (|valid_q));
    end

    // A launch only happens from an idle ONESHOT engine in a stable mode.
    assign launch = start && (mode_cur == MODE_ONESHOT) && !busy && !mode_chg;

    // Per-channel tick generation, handshake tracking and next-state logic.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            // period=0 behaves as period=1: terminal count is 0, tick each cycle.
            eff_m1[i] = (period[i*CNT_W +: CNT_W] == '0) ? '0
                        : period[i*CNT_W +: CNT_W] - CNT_W'(1);

            cnt_en[i] = 1'b0;
            if (en && !mode_chg) begin
                case (mode_cur)
                    MODE_PERIODIC: cnt_en[i] = 1'b1;
                    MODE_ONESHOT:  cnt_en[i] = rem_nz[i];
                    default:       cnt_en[i] = 1'b0;
                endcase
            end

            // ">=" lets a shrinking period take effect without waiting for wrap.
            // CONT ticks every enabled cycle and leaves cnt untouched.
            tick[i] = (cnt_en[i] && (cnt_q[i] >= eff_m1[i]))
                      || (en && (mode_cur == MODE_CONT));

            xfer[i]    = valid_q[i] & out_ready[i];
            valid_d[i] = tick[i] | (valid_q[i] & ~out_ready[i]);
            // A new set beats a simultaneous clear.
            ovr_d[i]   = (tick[i] & valid_q[i] & ~out_ready[i])
                         | (ovr_q[i] & ~clr_ovr);
            samp_d[i]  = samp_q[i] + SAMP_W'(xfer[i]);

            cnt_d[i] = cnt_q[i];
            rem_d[i] = rem_q[i];
            if (mode_chg) begin
                cnt_d[i] = '0;
                rem_d[i] = '0;
            end else if (launch) begin
                cnt_d[i] = '0;
                rem_d[i] = burst_len;
            end else if (cnt_en[i]) begin
                if (tick[i]) begin
                    cnt_d[i] = '0;
                    // Dropped ticks still consume burst budget.
                    if (mode_cur == MODE_ONESHOT) begin
                        rem_d[i] = rem_q[i] - CNT_W'(1);
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // State registers; reset abandons any pending sample or burst.
    always_ff @(posedge clk) begin
        mode_prev_q <= mode_cur;
        if (rn) begin
            valid_q <= '0;
            ovr_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]  <= '0;
                rem_q[i]  <= '0;
                samp_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            for (int unsigned i = 0; i < NCH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                rem_q[i]  <= rem_d[i];
                samp_q[i] <= samp_d[i];
            end
        end
    end

    assign out_valid = valid_q;
    assign overrun   = ovr_q;

    for (genvar g = 0; g < NCH; g++) begin : g_samp
        assign samp_cnt[g*SAMP_W +: SAMP_W] = samp_q[g];
    end

endmodule

// File: tb/tb_gen_valid_mc.sv
// tb_gen_valid_mc: directed checks of gen_valid_mc with hand-computed expectations.
module tb_gen_valid_mc;

    logic         clk;
    logic         rn, en, start, clr_ovr;
    logic [1:0]   mode;
    logic [63:0]  period;
    logic [15:0]  burst_len;
    logic [3:0]   out_ready, out_valid, overrun;
    logic [127:0] samp_cnt;
    logic         busy;

    // Narrow-counter instance for the wrap check.
    logic         rn2, en2, start2, clr2;
    logic [1:0]   mode2;
    logic [7:0]   period2, burst2;
    logic [0:0]   ready2, valid2, ovr2;
    logic [3:0]   samp2;
    logic         busy2;

    int tests = 0;
    int fails = 0;

    gen_valid_mc dut (
        .clk(clk), .rn(rn), .en(en), .mode(mode), .period(period),
        .burst_len(burst_len), .start(start), .clr_ovr(clr_ovr),
        .out_ready(out_ready), .out_valid(out_valid), .samp_cnt(samp_cnt),
        .overrun(overrun), .busy(busy)
    );

    gen_valid_mc #(.NCH(1), .CNT_W(8), .SAMP_W(4)) dut2 (
        .clk(clk), .rn(rn2), .en(en2), .mode(mode2), .period(period2),
        .burst_len(burst2), .start(start2), .clr_ovr(clr2),
        .out_ready(ready2), .out_valid(valid2), .samp_cnt(samp2),
        .overrun(ovr2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_per(input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
        period = {p3, p2, p1, p0};
    endtask

    initial begin
        rn = 1'b1; en = 1'b1; start = 1'b0; clr_ovr = 1'b0; mode = 2'd0;
        burst_len = 16'd0; out_ready = 4'hF;
        set_per(16'd5, 16'd5, 16'd5, 16'd2);
        rn2 = 1'b1; en2 = 1'b1; start2 = 1'b0; clr2 = 1'b0; mode2 = 2'd2;
        period2 = 8'd1; burst2 = 8'd0; ready2 = 1'b1;
        step(2);

        // Reset state
        check("rst_valid", out_valid, 4'h0);
        check("rst_samp",  samp_cnt[63:0], 64'd0);
        check("rst_ovr",   overrun, 4'h0);
        check("rst_busy",  busy, 1'b0);

        // PERIODIC period=5 (ch3 period=2), always ready
        rn = 1'b0;
        step(4);
        check("per_e4_valid", out_valid, 4'b1000);
        step(1);
        check("per_e5_valid", out_valid, 4'b0111);
        step(1);
        check("per_e6_valid", out_valid, 4'b1000);
        check("per_e6_samp0", samp_cnt[31:0], 32'd1);
        step(15);
        check("per_e21_samp0", samp_cnt[31:0], 32'd4);
        check("per_e21_samp3", samp_cnt[127:96], 32'd10);
        check("per_e21_valid", out_valid, 4'h0);
        check("per_e21_ovr", overrun, 4'h0);

        // PERIODIC period=3 with stalled consumer, then overrun clear
        rn = 1'b1; set_per(16'd3, 16'd3, 16'd3, 16'd3); out_ready = 4'h0;
        step(1);
        rn = 1'b0;
        step(5);
        check("stall_e5_valid", out_valid, 4'hF);
        check("stall_e5_ovr", overrun, 4'h0);
        step(1);
        check("stall_e6_ovr", overrun, 4'hF);
        step(4);
        check("stall_e10_valid", out_valid, 4'hF);
        check("stall_e10_samp", samp_cnt[31:0], 32'd0);
        out_ready = 4'hF;
        step(1);
        check("stall_e11_samp", samp_cnt[31:0], 32'd1);
        check("stall_e11_valid", out_valid, 4'h0);
        check("stall_e11_ovr", overrun, 4'hF);
        clr_ovr = 1'b1;
        step(1);
        check("clr_ovr", overrun, 4'h0);
        check("clr_e12_valid", out_valid, 4'hF);
        clr_ovr = 1'b0; out_ready = 4'h0;
        step(2);
        check("e14_ovr", overrun, 4'h0);
        clr_ovr = 1'b1;
        step(1);
        check("set_wins_ovr", overrun, 4'hF);
        clr_ovr = 1'b0;

        // ONESHOT burst_len=3 period=2, second start ignored while busy
        rn = 1'b1; mode = 2'd1; set_per(16'd2, 16'd2, 16'd2, 16'd2);
        burst_len = 16'd3; out_ready = 4'hF;
        step(1);
        rn = 1'b0;
        step(2);
        check("os_idle_busy", busy, 1'b0);
        check("os_idle_valid", out_valid, 4'h0);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("os_s1_busy", busy, 1'b1);
        step(1);
        check("os_s2_valid", out_valid, 4'h0);
        step(1);
        check("os_s3_valid", out_valid, 4'hF);
        start = 1'b1; burst_len = 16'd7;
        step(1);
        start = 1'b0;
        check("os_s4_samp0", samp_cnt[31:0], 32'd1);
        check("os_s4_busy", busy, 1'b1);
        step(3);
        check("os_s7_valid", out_valid, 4'hF);
        check("os_s7_busy", busy, 1'b1);
        step(1);
        check("os_s8_samp2", samp_cnt[95:64], 32'd3);
        check("os_s8_busy", busy, 1'b0);
        check("os_s8_valid", out_valid, 4'h0);
        step(6);
        check("os_after_samp0", samp_cnt[31:0], 32'd3);
        check("os_after_valid", out_valid, 4'h0);
        // burst_len=0 launches nothing
        burst_len = 16'd0; start = 1'b1;
        step(1);
        start = 1'b0;
        check("os_zero_busy", busy, 1'b0);
        step(4);
        check("os_zero_valid", out_valid, 4'h0);
        check("os_zero_samp1", samp_cnt[63:32], 32'd3);

        // period 0/1 tick every cycle, then CONT, then OFF
        rn = 1'b1; mode = 2'd0; set_per(16'd0, 16'd1, 16'd0, 16'd1); out_ready = 4'hF;
        step(1);
        rn = 1'b0;
        step(1);
        check("p01_e1_valid", out_valid, 4'hF);
        step(9);
        check("p01_e10_samp0", samp_cnt[31:0], 32'd9);
        check("p01_e10_samp1", samp_cnt[63:32], 32'd9);
        check("p01_e10_valid", out_valid, 4'hF);
        check("p01_e10_ovr", overrun, 4'h0);
        mode = 2'd2;
        step(5);
        check("cont_samp0", samp_cnt[31:0], 32'd14);
        check("cont_valid", out_valid, 4'hF);
        mode = 2'd3;
        step(1);
        check("off_valid", out_valid, 4'h0);
        check("off_samp0", samp_cnt[31:0], 32'd15);
        step(3);
        check("off_hold_valid", out_valid, 4'h0);
        check("off_hold_samp3", samp_cnt[127:96], 32'd15);

        // Reset mid-burst with a pending valid
        rn = 1'b1; mode = 2'd1; set_per(16'd2, 16'd2, 16'd2, 16'd2);
        burst_len = 16'd3; out_ready = 4'h0;
        step(1);
        rn = 1'b0; start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        check("mid_valid", out_valid, 4'hF);
        check("mid_busy", busy, 1'b1);
        rn = 1'b1; out_ready = 4'hF;
        step(1);
        check("rst_mid_valid", out_valid, 4'h0);
        check("rst_mid_samp0", samp_cnt[31:0], 32'd0);
        check("rst_mid_ovr", overrun, 4'h0);
        check("rst_mid_busy", busy, 1'b0);
        mode = 2'd0; set_per(16'd4, 16'd4, 16'd4, 16'd4);
        step(1);
        rn = 1'b0;
        step(3);
        check("post_rst_e3_valid", out_valid, 4'h0);
        step(1);
        check("post_rst_e4_valid", out_valid, 4'hF);

        // en=0 freezes the period counter
        rn = 1'b1; set_per(16'd5, 16'd5, 16'd5, 16'd5);
        step(1);
        rn = 1'b0;
        step(2);
        en = 1'b0;
        step(10);
        check("frz_valid", out_valid, 4'h0);
        en = 1'b1;
        step(2);
        check("frz_e14_valid", out_valid, 4'h0);
        step(1);
        check("frz_e15_valid", out_valid, 4'hF);

        // SAMP_W=4 wrap: 17 transfers -> 1
        rn2 = 1'b0;
        step(1);
        check("wrap_e1_valid", valid2, 1'b1);
        check("wrap_e1_samp", samp2, 4'd0);
        step(17);
        check("wrap_samp", samp2, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gen_valid_mc.md
GEN_VALID_MC -- requirements
Module: gen_valid_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent valid channels.
REQ-002 SHALL have parameter CNT_W, default 16, width of the period, burst-length and per-channel cycle counters.
REQ-003 SHALL have parameter SAMP_W, default 32, width of each per-channel accepted-sample counter.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rn, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port en, input, 1, global count enable.
REQ-007 SHALL have port mode, input, 2, 0=PERIODIC, 1=ONESHOT, 2=CONT, 3=OFF.
REQ-008 SHALL have port period, input, NCH*CNT_W, per-channel tick period in cycles; channel i at bits [i*CNT_W +: CNT_W].
REQ-009 SHALL have port burst_len, input, CNT_W, tick count per ONESHOT run; shared by all channels.
REQ-010 SHALL have port start, input, 1, ONESHOT launch pulse.
REQ-011 SHALL have port clr_ovr, input, 1, clears all overrun flags.
REQ-012 SHALL have port out_ready, input, NCH, per-channel consumer ready.
REQ-013 SHALL have port out_valid, output, NCH, per-channel registered valid.
REQ-014 SHALL have port samp_cnt, output, NCH*SAMP_W, per-channel accepted-transfer count.
REQ-015 SHALL have port overrun, output, NCH, per-channel sticky tick-dropped flag.
REQ-016 SHALL have port busy, output, 1, ONESHOT run in progress.

Function
REQ-017 Per channel, cnt SHALL advance only while en=1 and mode is PERIODIC, or ONESHOT with remaining>0; otherwise it holds.
REQ-018 A tick SHALL occur when cnt>=eff_period-1 with counting enabled; cnt then wraps to 0 on the next edge. eff_period is period, or 1 when period=0 (tick every cycle); ">=" makes a period shrink take effect immediately.
REQ-019 out_valid[i] SHALL rise on the edge after a tick, giving 1-cycle tick-to-valid latency.
REQ-020 A transfer SHALL be out_valid[i]&out_ready[i]; valid SHALL hold high until a transfer and SHALL fall on the edge after it unless a new tick arrives.
REQ-021 Tick and transfer in the same cycle SHALL keep out_valid[i]=1 for a new sample and SHALL NOT set overrun.
REQ-022 A tick while out_valid[i]=1 and out_ready[i]=0 SHALL be dropped, and overrun[i] SHALL be set on the next edge.
REQ-023 overrun SHALL clear on clr_ovr=1; if a set and a clear coincide, the set SHALL win.
REQ-024 samp_cnt[i] SHALL increment by 1 on every transfer and SHALL wrap modulo 2^SAMP_W; it SHALL NOT be cleared by a mode change.
REQ-025 In CONT mode with en=1, out_valid[i] SHALL be high on every cycle, with one transfer per cycle while ready; cnt SHALL hold.
REQ-026 ONESHOT: start=1 while busy=0 SHALL load remaining[i]=burst_len and cnt=0 for every channel; start while busy=1 SHALL be ignored.
REQ-027 ONESHOT: each tick SHALL decrement remaining[i]; ticks SHALL stop when remaining[i]=0; a dropped tick SHALL still decrement.
REQ-028 burst_len=0 on start SHALL produce no ticks, and busy SHALL stay 0.
REQ-029 busy SHALL be OR over channels of (remaining[i]!=0 | out_valid[i]) while mode=ONESHOT, and 0 otherwise.
REQ-030 en=0 SHALL freeze cnt and remaining; a pending valid SHALL still complete its handshake.
REQ-031 Any change of mode SHALL clear cnt and remaining on the next edge; a pending valid SHALL be kept.
REQ-032 OFF mode SHALL generate no new ticks; pending valids SHALL still complete their handshakes.

Reset
REQ-033 rn=1 at a clock edge SHALL set out_valid=0, samp_cnt=0, overrun=0, cnt=0, remaining=0 and busy=0, overriding all other inputs.
REQ-034 Reset mid-handshake or mid-burst SHALL abandon the sample or burst; no transfer SHALL be counted on the reset cycle.

Verification
REQ-035 PERIODIC, period=5, en=1, ready=1 -> valid one cycle in every 5, first valid 5 cycles after reset release, samp_cnt=4 after 20 cycles.
REQ-036 PERIODIC, period=3, ready=0 for 10 cycles -> valid held high, overrun=1 from the 2nd tick, samp_cnt=0; ready=1 -> samp_cnt=1; clr_ovr -> overrun=0.
REQ-037 ONESHOT, burst_len=3, period=2, start -> exactly 3 transfers per channel, busy falls after the last transfer, a second start during busy is ignored.
REQ-038 period=0 and period=1 -> valid on every cycle; simultaneous tick and transfer keeps valid high with overrun=0.
REQ-039 samp_cnt preset near wrap (SAMP_W=4, 17 transfers) -> samp_cnt=1.
REQ-040 rn=1 asserted while valid=1 and mid-burst -> all outputs 0 on the next edge; no spurious valid after release until a full period elapses.
